// File: rtl/sha256_msg_padder_if.sv
// Job, memory-read and padded-word stream signals of the SHA-256 message padder.
// The master side is the padder; the slave side is its environment (memory and consumer).
interface sha256_msg_padder_if;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] num_words;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [31:0] blk_word;
    logic        blk_valid;
    logic        blk_ready;
    logic        blk_last;
    logic        msg_last;
    logic        busy;
    logic        done;

    modport master (
        input  start, message_addr, num_words, mem_read_data, blk_ready,
        output mem_addr, blk_word, blk_valid, blk_last, msg_last, busy, done
    );

    modport slave (
        output start, message_addr, num_words, mem_read_data, blk_ready,
        input  mem_addr, blk_word, blk_valid, blk_last, msg_last, busy, done
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streams an N-word message from synchronous-read memory as a SHA-256 padded word sequence:
// message words, 0x80000000, zero fill, then the 64-bit big-endian bit length.
module sha256_msg_padder (
    input  logic                clk,
    input  logic                reset_n,
    sha256_msg_padder_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_SEND} state_t;

    state_t      r_state;
    logic [15:0] r_base;
    logic [15:0] r_n;
    logic [16:0] r_k;
    logic [16:0] r_last_k;
    logic [15:0] r_mem_addr;
    logic [31:0] r_word;
    logic        r_valid;
    logic        r_blk_last;
    logic        r_msg_last;
    logic        r_busy;
    logic        r_done;

    logic [16:0] w_sum;
    logic [16:0] w_start_last_k;
    logic [16:0] w_k_next;
    logic        w_xfer;
    logic        w_next_is_msg;
    logic [31:0] w_gen_word;

    always_comb begin
        // T-1 = 16*((N+18)>>4) - 1: force the low nibble to F, then step back one block
        w_sum          = {1'b0, bus.num_words} + 17'd18;
        w_start_last_k = (w_sum | 17'h0000F) - 17'd16;
        w_k_next       = r_k + 17'd1;
        w_xfer         = r_valid && bus.blk_ready;
        w_next_is_msg  = w_k_next < {1'b0, r_n};
        if (w_k_next == {1'b0, r_n})
            w_gen_word = 32'h8000_0000;
        else if (w_k_next == r_last_k)
            w_gen_word = {11'b0, r_n, 5'b0};
        else
            w_gen_word = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_last_k   <= '0;
            r_mem_addr <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_blk_last <= 1'b0;
            r_msg_last <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base   <= bus.message_addr;
                        r_n      <= bus.num_words;
                        r_last_k <= w_start_last_k;
                        r_k      <= '0;
                        r_busy   <= 1'b1;
                        if (bus.num_words == '0) begin
                            r_word     <= 32'h8000_0000;
                            r_valid    <= 1'b1;
                            r_blk_last <= 1'b0;
                            r_msg_last <= 1'b0;
                            r_state    <= S_SEND;
                        end else begin
                            r_mem_addr <= bus.message_addr;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: r_state <= S_CAPT;
                S_CAPT: begin
                    r_word     <= bus.mem_read_data;
                    r_valid    <= 1'b1;
                    r_blk_last <= (r_k[3:0] == 4'hF);
                    r_msg_last <= (r_k == r_last_k);
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_k == r_last_k) begin
                            r_state    <= S_IDLE;
                            r_k        <= '0;
                            r_valid    <= 1'b0;
                            r_blk_last <= 1'b0;
                            r_msg_last <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_k <= w_k_next;
                            if (w_next_is_msg) begin
                                r_state    <= S_REQ;
                                r_valid    <= 1'b0;
                                r_blk_last <= 1'b0;
                                r_msg_last <= 1'b0;
                                r_mem_addr <= r_base + w_k_next[15:0];
                            end else begin
                                r_word     <= w_gen_word;
                                r_blk_last <= (w_k_next[3:0] == 4'hF);
                                r_msg_last <= (w_k_next == r_last_k);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.blk_word  = r_word;
    assign bus.blk_valid = r_valid;
    assign bus.blk_last  = r_blk_last;
    assign bus.msg_last  = r_msg_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed and randomized jobs for sha256_msg_padder, checked against a padded-stream
// model built from N, the start address and a behavioural synchronous-read memory.
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [31:0] mem [0:65535];

    sha256_msg_padder_if bus ();

    sha256_msg_padder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.blk_valid), 64'd0);
        check({tag, "_busy"},  64'(bus.busy),      64'd0);
        check({tag, "_done"},  64'(bus.done),      64'd0);
        check({tag, "_word"},  64'(bus.blk_word),  64'd0);
        check({tag, "_lasts"}, 64'({bus.blk_last, bus.msg_last}), 64'd0);
        check({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
    endtask

    // mode: 0 = ready always high, 1 = ready toggles each cycle, 2 = random ready
    task automatic run_job(input logic [15:0] addr, input int n, input int mode,
                           input bit seq_data, input bit disturb, input int abort_at);
        logic [31:0] exp_w[$];
        bit          exp_bl[$];
        bit          exp_ml[$];
        int          t, idx, cycles, busy_cycles, budget;
        bit          prev_stall, rdy, prev_bl, prev_ml;
        logic [31:0] prev_word;
        logic [31:0] w;

        t = 16 * ((n + 18) / 16);
        for (int k = 0; k < n; k++)
            mem[(int'(addr) + k) % 65536] = seq_data ? 32'(k + 1) : $urandom;
        for (int k = 0; k < t; k++) begin
            if (k < n)           w = mem[(int'(addr) + k) % 65536];
            else if (k == n)     w = 32'h8000_0000;
            else if (k == t - 1) w = 32'(n * 32);
            else                 w = 32'h0;
            exp_w.push_back(w);
            exp_bl.push_back((k % 16) == 15);
            exp_ml.push_back(k == t - 1);
        end

        @(negedge clk);
        bus.message_addr = addr;
        bus.num_words    = 16'(n);
        bus.start        = 1'b1;
        bus.blk_ready    = 1'b0;

        idx = 0; cycles = 0; busy_cycles = 0; prev_stall = 1'b0;
        prev_word = '0; prev_bl = 1'b0; prev_ml = 1'b0;
        budget = 6 * (2 * n + t) + 40;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (disturb && bus.busy) begin
                bus.start        = 1'($urandom_range(0, 1));
                bus.num_words    = 16'($urandom);
                bus.message_addr = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cycles++;
            check("done_busy_excl", 64'(bus.done & bus.busy), 64'd0);
            if (idx == t) begin
                check("done_pulse", 64'({bus.done, bus.busy, bus.blk_valid}), 64'b100);
                break;
            end
            if (prev_stall)
                check("hold_stable", 64'({bus.blk_valid, bus.blk_last, bus.msg_last, bus.blk_word}),
                      64'({1'b1, prev_bl, prev_ml, prev_word}));
            if (abort_at == idx && bus.blk_valid) begin
                reset_n   = 1'b0;
                bus.start = 1'b0;
                #1;
                check_idle_outputs("abort_reset");
                bus.blk_ready = 1'b1;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("post_reset_quiet", 64'({bus.blk_valid, bus.busy}), 64'd0);
                end
                bus.blk_ready = 1'b0;
                return;
            end
            if (cycles > budget) begin
                check("timeout_words", 64'(idx), 64'(t));
                bus.start = 1'b0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cycles[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.blk_ready = rdy;
            if (bus.blk_valid && rdy) begin
                check($sformatf("word%0d_n%0d", idx, n), 64'(bus.blk_word), 64'(exp_w[idx]));
                check($sformatf("lasts%0d_n%0d", idx, n), 64'({bus.blk_last, bus.msg_last}),
                      64'({exp_bl[idx], exp_ml[idx]}));
                idx++;
            end
            prev_stall = bus.blk_valid && !rdy;
            prev_word  = bus.blk_word;
            prev_bl    = bus.blk_last;
            prev_ml    = bus.msg_last;
        end
        bus.start     = 1'b0;
        bus.blk_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 64'({bus.done, bus.busy, bus.blk_valid}), 64'd0);
        if (mode == 0 && !disturb)
            check($sformatf("busy_cycles_n%0d", n), 64'(busy_cycles), 64'(2 * n + t));
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.blk_ready    = 1'b0;
        bus.message_addr = '0;
        bus.num_words    = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset_n       = 1'b1;
        bus.blk_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_quiet", 64'({bus.blk_valid, bus.busy, bus.done}), 64'd0);
        end
        bus.blk_ready = 1'b0;

        run_job(16'h0100, 0,  0, 1'b1, 1'b0, -1);
        run_job(16'h0200, 13, 0, 1'b1, 1'b0, -1);
        run_job(16'h0300, 14, 0, 1'b1, 1'b0, -1);
        run_job(16'hFFFE, 20, 1, 1'b1, 1'b0, -1);
        run_job(16'h1234, 30, 2, 1'b0, 1'b1, -1);
        run_job(16'h0400, 20, 0, 1'b0, 1'b0, 5);
        run_job(16'h0400, 20, 0, 1'b0, 1'b0, -1);
        run_job(16'h0500, 2,  0, 1'b0, 1'b0, -1);
        for (int j = 0; j < 4; j++)
            run_job(16'($urandom), $urandom_range(0, 40), $urandom_range(0, 2), 1'b0,
                    1'($urandom_range(0, 1)), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
